// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: state encoding,
// reset fetch address and the program-counter increment helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_HOLD     = 2'd2,
    ST_REDIRECT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP        = 32'd4;

  // Address arithmetic wraps modulo 2^32 by construction (32-bit result).
  function automatic logic [31:0] pc_inc(input logic [31:0] addr);
    return addr + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Saturating wait counter for the memory handshake. hit reports that the
// value being loaded this cycle equals the limit, so the caller can flag
// the timeout on the same edge the counter reaches it.
module fetch_timeout_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       hit
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: clear wins, otherwise count up and stick at the limit.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (enable && (count_q != limit)) begin
      count_d = count_q + 8'd1;
    end
  end

  assign hit = (count_d == limit);

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Single-outstanding instruction fetch controller with branch redirect,
// one-entry instruction hold and a sticky memory timeout flag.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | one cycle after reset release, no request
// FETCH    | request outstanding at fetch_pc, waiting for imem_ack
// HOLD     | instruction held for the decode stage, no request
// REDIRECT | branch seen mid-request; drain old request, then jump
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        valid,
  output logic        freeze,
  output logic        timeout_err
);

  fetch_state_e state_q;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  target_q;
  logic [31:0]  instr_q;
  logic [31:0]  pc_q;
  logic         valid_q;
  logic         imem_req_q;
  logic [31:0]  imem_addr_q;
  logic         timeout_q;

  logic         ack_eff;
  logic         wait_clear_d;
  logic         wait_enable;
  logic         wait_hit;

  // An ack only counts while a request is actually outstanding.
  assign ack_eff     = imem_ack & imem_req_q;
  assign wait_enable = imem_req_q & ~imem_ack;

  // Counter clears on any accepted ack and on every entry into FETCH/REDIRECT.
  always_comb begin
    wait_clear_d = ack_eff;
    unique case (state_q)
      ST_IDLE:  wait_clear_d = 1'b1;
      ST_HOLD:  if (branch_taken || (valid_q && !stall_in)) wait_clear_d = 1'b1;
      ST_FETCH: if (branch_taken && !imem_ack) wait_clear_d = 1'b1;
      default:  ;
    endcase
  end

  fetch_timeout_counter u_wait_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (wait_clear_d),
    .enable (wait_enable),
    .limit  (TIMEOUT),
    .hit    (wait_hit)
  );

  // Fetch sequencing FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC;
      target_q    <= 32'd0;
      instr_q     <= 32'd0;
      pc_q        <= 32'd0;
      valid_q     <= 1'b0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= 32'd0;
      timeout_q   <= 1'b0;
    end else begin
      if (wait_hit && imem_req_q) begin
        timeout_q <= 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          state_q    <= ST_FETCH;
          imem_req_q <= 1'b1;
          if (branch_taken) begin
            fetch_pc_q  <= branch_address;
            imem_addr_q <= branch_address;
          end else begin
            imem_addr_q <= fetch_pc_q;
          end
        end
        ST_FETCH: begin
          if (imem_ack) begin
            if (branch_taken) begin
              // Returned data belongs to the wrong path; refetch at target.
              fetch_pc_q  <= branch_address;
              imem_addr_q <= branch_address;
            end else begin
              instr_q    <= imem_rdata;
              pc_q       <= pc_inc(fetch_pc_q);
              valid_q    <= 1'b1;
              fetch_pc_q <= pc_inc(fetch_pc_q);
              imem_req_q <= 1'b0;
              state_q    <= ST_HOLD;
            end
          end else if (branch_taken) begin
            target_q <= branch_address;
            state_q  <= ST_REDIRECT;
          end
        end
        ST_REDIRECT: begin
          if (imem_ack) begin
            // A branch arriving with the ack is the most recent one and wins.
            if (branch_taken) begin
              fetch_pc_q  <= branch_address;
              imem_addr_q <= branch_address;
            end else begin
              fetch_pc_q  <= target_q;
              imem_addr_q <= target_q;
            end
            state_q <= ST_FETCH;
          end else if (branch_taken) begin
            target_q <= branch_address;
          end
        end
        ST_HOLD: begin
          if (branch_taken) begin
            valid_q     <= 1'b0;
            fetch_pc_q  <= branch_address;
            imem_addr_q <= branch_address;
            imem_req_q  <= 1'b1;
            state_q     <= ST_FETCH;
          end else if (valid_q && !stall_in) begin
            valid_q     <= 1'b0;
            imem_addr_q <= fetch_pc_q;
            imem_req_q  <= 1'b1;
            state_q     <= ST_FETCH;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign valid       = valid_q;
  assign freeze      = ~valid_q;
  assign timeout_err = timeout_q;

endmodule
